// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU memory interface. Accepts a held
// mem_read/mem_write request, waits LATENCY cycles, performs the access
// against a word-addressed RAM and returns a one-cycle mem_resp pulse.
module cpu_mem_responder #(
  parameter int    ADDR_WIDTH = 10,
  parameter int    LATENCY    = 2,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  output logic        mem_resp,
  output logic [31:0] mem_rdata,
  output logic        mem_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Request captured at acceptance; no reset needed, only read while BUSY.
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        rd_q;
  logic        both_q;

  logic [31:0] ram_q [DEPTH];

  logic                  req;
  logic                  acc;
  logic [29:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [3:0]            acc_be;
  logic                  acc_rd;
  logic                  acc_both;
  logic                  acc_inrange;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic                  ram_we;
  logic                  unused_addr_lsb;

  assign req             = mem_read | mem_write;
  assign unused_addr_lsb = ^mem_address[1:0];

  // Access operands: live inputs when completing straight from IDLE
  // (LATENCY = 1), otherwise the values captured at acceptance.
  always_comb begin
    if (state_q == IDLE) begin
      acc_addr  = mem_address[31:2];
      acc_wdata = mem_wdata;
      acc_be    = mem_byte_enable;
      acc_rd    = mem_read;
      acc_both  = mem_read & mem_write;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
      acc_rd    = rd_q;
      acc_both  = both_q;
    end
    acc_idx     = acc_addr[ADDR_WIDTH-1:0];
    acc_inrange = (acc_addr[29:ADDR_WIDTH] == '0);
  end

  // Next-state logic and registered output updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    resp_d  = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    acc     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = RESP;
            acc     = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!req) begin
          // CPU withdrew the request early: drop it and flag the violation.
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
          acc     = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // The still-held request is ignored here; it was already serviced.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (acc) begin
      resp_d = 1'b1;
      if (acc_rd) rdata_d = acc_inrange ? ram_q[acc_idx] : 32'h0;
      if (!acc_inrange || acc_both) err_d = 1'b1;
    end
  end

  // Gated by rst so an access cannot land while reset is asserted.
  assign ram_we = acc & ~acc_rd & acc_inrange & ~rst;

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      resp_q  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Capture the request operands at acceptance.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req) begin
      addr_q  <= mem_address[31:2];
      wdata_q <= mem_wdata;
      be_q    <= mem_byte_enable;
      rd_q    <= mem_read;
      both_q  <= mem_read & mem_write;
    end
  end

  // Byte-lane write into the backing RAM.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) ram_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: five instances with LATENCY 1..5 driven by
// directed transactions; expected responses queued and popped on mem_resp.
module tb_cpu_mem_responder;

  localparam int ND = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd    [ND];
  logic        wr    [ND];
  logic [3:0]  be    [ND];
  logic [31:0] addr  [ND];
  logic [31:0] wd    [ND];
  logic        resp  [ND];
  logic [31:0] rdat  [ND];
  logic        err   [ND];

  genvar g;
  generate
    for (g = 0; g < ND; g++) begin : g_dut
      cpu_mem_responder #(.ADDR_WIDTH(10), .LATENCY(g + 1)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (rd[g]),
        .mem_write      (wr[g]),
        .mem_byte_enable(be[g]),
        .mem_address    (addr[g]),
        .mem_wdata      (wd[g]),
        .mem_resp       (resp[g]),
        .mem_rdata      (rdat[g]),
        .mem_err        (err[g])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rd [ND];
  logic        err_m   [ND];
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance d, held until mem_resp.
  task automatic xact(input int d, input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] data, input logic [3:0] b,
                      input logic [31:0] exp_rd, input bit sets_err, output time t_resp);
    exp_t e;
    exp_t got_e;
    int   n;
    bit   got;
    if (r) last_rd[d] = exp_rd;
    err_m[d] = err_m[d] | sets_err;
    e.rdata  = last_rd[d];
    e.err    = err_m[d];
    sb.push_back(e);
    @(negedge clk);
    rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = data; be[d] = b;
    got = 1'b0; n = 0; t_resp = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (resp[d]) got = 1'b1;
    end
    check("resp_seen", 32'(got), 32'd1);
    check("latency", 32'(n), 32'(d + 1));
    got_e = sb.pop_front();
    if (got) begin
      t_resp = $time;
      check("rdata", rdat[d], got_e.rdata);
      check("err", 32'(err[d]), 32'(got_e.err));
    end
    @(posedge clk); #1;
    check("resp_one_cycle", 32'(resp[d]), 32'd0);
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  time t0, t1, t2;
  int  dd;
  bit  seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < ND; i++) begin
      rd[i] = 0; wr[i] = 0; be[i] = 0; addr[i] = 0; wd[i] = 0;
      last_rd[i] = 0; err_m[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++) begin
      check("reset_resp", 32'(resp[i]), 32'd0);
      check("reset_rdata", rdat[i], 32'h0);
      check("reset_err", 32'(err[i]), 32'd0);
    end
    @(negedge clk); rst = 1'b0;

    // Basic write then read, LATENCY 2.
    xact(1, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, t0);
    xact(1, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, t0);

    // Byte-lane merge and an all-lanes-off write.
    xact(1, 0, 1, 32'h20, 32'h11223344, 4'hF, 0, 0, t0);
    xact(1, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 0, t0);
    xact(1, 1, 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, t0);
    xact(1, 0, 1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 0, t0);
    xact(1, 1, 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, t0);

    // Back-to-back reads at LATENCY 1 and 5.
    for (int k = 0; k < 2; k++) begin
      dd = (k == 0) ? 0 : 4;
      xact(dd, 0, 1, 32'h40, 32'hC0DE0040 + dd, 4'hF, 0, 0, t0);
      xact(dd, 0, 1, 32'h44, 32'hC0DE0044 + dd, 4'hF, 0, 0, t0);
      xact(dd, 1, 0, 32'h40, 0, 0, 32'hC0DE0040 + dd, 0, t0);
      xact(dd, 1, 0, 32'h44, 0, 0, 32'hC0DE0044 + dd, 0, t1);
      xact(dd, 1, 0, 32'h40, 0, 0, 32'hC0DE0040 + dd, 0, t2);
      check("b2b_spacing1", 32'(t1 - t0), 32'((dd + 2) * 10));
      check("b2b_spacing2", 32'(t2 - t1), 32'((dd + 2) * 10));
    end

    // Out-of-range read and write; word 0 aliases the dropped write.
    xact(1, 0, 1, 32'h0, 32'h5A5A5A5A, 4'hF, 0, 0, t0);
    xact(1, 1, 0, 32'h1000, 0, 0, 32'h0, 1, t0);
    xact(1, 0, 1, 32'h1000, 32'h12345678, 4'hF, 0, 1, t0);
    xact(1, 1, 0, 32'h0, 0, 0, 32'h5A5A5A5A, 0, t0);

    // Abort: write withdrawn in cycle 1 at LATENCY 3.
    xact(2, 0, 1, 32'h80, 32'h13579BDF, 4'hF, 0, 0, t0);
    @(negedge clk);
    wr[2] = 1'b1; addr[2] = 32'h80; wd[2] = 32'hFFFFFFFF; be[2] = 4'hF;
    @(posedge clk); #1;
    wr[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp[2]) seen = 1'b1;
    end
    check("abort_no_resp", 32'(seen), 32'd0);
    check("abort_err", 32'(err[2]), 32'd1);
    err_m[2] = 1'b1;
    xact(2, 1, 0, 32'h80, 0, 0, 32'h13579BDF, 0, t0);

    // Reset in cycle 2 of an in-flight write at LATENCY 4.
    xact(3, 0, 1, 32'hC0, 32'h0BADF00D, 4'hF, 0, 0, t0);
    xact(3, 1, 0, 32'h1004, 0, 0, 32'h0, 1, t0);
    xact(3, 1, 0, 32'hC0, 0, 0, 32'h0BADF00D, 0, t0);
    @(negedge clk);
    wr[3] = 1'b1; addr[3] = 32'hC0; wd[3] = 32'hFFFFFFFF; be[3] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_resp", 32'(resp[3]), 32'd0);
    check("midrst_rdata", rdat[3], 32'h0);
    check("midrst_err", 32'(err[3]), 32'd0);
    @(negedge clk);
    rst = 1'b0; wr[3] = 1'b0;
    for (int i = 0; i < ND; i++) begin
      last_rd[i] = 0; err_m[i] = 0;
    end
    xact(3, 1, 0, 32'hC0, 0, 0, 32'h0BADF00D, 0, t0);

    // Read and write both asserted: serviced as a read, flagged.
    xact(1, 0, 1, 32'h100, 32'h600DCAFE, 4'hF, 0, 0, t0);
    xact(1, 1, 1, 32'h100, 32'hFFFFFFFF, 4'hF, 32'h600DCAFE, 1, t0);
    xact(1, 1, 0, 32'h100, 0, 0, 32'h600DCAFE, 0, t0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
